ariane_wakeup_ctrl: RTL and testbench

//  Per-tile core reset sequencer and async-input synchronizer for the OpenPiton Ariane wrapper.

---
 rtl/ariane_pkg.sv | 33 +++
 rtl/ariane_wakeup_ctrl_sync_chain.sv | 27 ++
 rtl/ariane_wakeup_ctrl.sv | 159 +++++++++++++++
 tb/tb_ariane_wakeup_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared types and elaboration helpers for the Ariane tile wakeup controller.
package ariane_pkg;

  typedef enum logic [1:0] {
    WAKE_WAIT    = 2'd0,
    WAKE_RELEASE = 2'd1,
    WAKE_RUN     = 2'd2,
    WAKE_HOLD    = 2'd3
  } wake_state_e;

  typedef enum logic [1:0] {
    WAKE_COUNT           = 2'd0,
    WAKE_EVENT           = 2'd1,
    WAKE_COUNT_AND_EVENT = 2'd2
  } wake_mode_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Wide enough to hold the largest terminal count of any phase.
  function automatic int unsigned wake_cnt_width(input int unsigned wake_cycles,
                                                 input int unsigned hold_cycles,
                                                 input int unsigned sync_stages);
    return $clog2(max3(wake_cycles, hold_cycles, sync_stages) + 1);
  endfunction

endpackage

// File: rtl/ariane_wakeup_ctrl_sync_chain.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear to 0.
module sync_chain #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic reset_l,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_d, sync_q;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/ariane_wakeup_ctrl.sv
// Per-tile core reset sequencer: waits for SRAM init and/or an L15 wake event,
// then releases a synchronized core reset and gates synchronized interrupts.
module ariane_wakeup_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned WakeMode   = 0,
  parameter int unsigned WakeCycles = 32768,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned NrIrq      = 2,
  parameter int unsigned HoldCycles = 16
) (
  input  logic             clk_i,
  input  logic             reset_l,
  input  logic             wake_evt_i,
  input  logic             soft_rst_req_i,
  input  logic [NrIrq-1:0] irq_async_i,
  input  logic             ipi_async_i,
  input  logic             time_irq_async_i,
  input  logic             debug_req_async_i,
  output logic             core_rst_no,
  output logic [NrIrq-1:0] irq_o,
  output logic             ipi_o,
  output logic             time_irq_o,
  output logic             debug_req_o,
  output logic [1:0]       state_o,
  output logic             wake_done_o
);

  localparam int unsigned     CntW     = wake_cnt_width(WakeCycles, HoldCycles, SyncStages);
  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [CntW-1:0] WakeLast = (WakeCycles == 0) ? '0 : CntW'(WakeCycles - 1);
  localparam logic [CntW-1:0] RelLast  = CntW'(SyncStages - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam wake_mode_e      Mode     = wake_mode_e'(WakeMode[1:0]);

  if (SyncStages < 2) begin : g_bad_sync_stages
    $error("ariane_wakeup_ctrl: SyncStages must be at least 2");
  end
  if (HoldCycles < SyncStages) begin : g_bad_hold_cycles
    $error("ariane_wakeup_ctrl: HoldCycles must be >= SyncStages");
  end
  if (WakeMode > 2) begin : g_bad_wake_mode
    $error("ariane_wakeup_ctrl: WakeMode must be 0, 1 or 2");
  end

  wake_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            evt_sticky_q, evt_sticky_d;
  logic            count_ok, evt_seen, wake_ok;

  // The counter saturates above WakeLast, so once met the count condition stays met.
  always_comb begin
    count_ok = (cnt_q >= WakeLast);
    evt_seen = wake_evt_i | evt_sticky_q;
    case (Mode)
      WAKE_EVENT:           wake_ok = wake_evt_i;
      WAKE_COUNT_AND_EVENT: wake_ok = count_ok & evt_seen;
      default:              wake_ok = count_ok;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    evt_sticky_d = 1'b0;
    case (state_q)
      WAKE_WAIT: begin
        if (wake_ok) begin
          state_d = WAKE_RELEASE;
        end else begin
          evt_sticky_d = evt_seen;
        end
      end
      WAKE_RELEASE: begin
        if (cnt_q == RelLast) state_d = WAKE_RUN;
      end
      WAKE_RUN: begin
        if (soft_rst_req_i) state_d = WAKE_HOLD;
      end
      WAKE_HOLD: begin
        if (cnt_q == HoldLast) state_d = WAKE_RELEASE;
      end
      default: state_d = WAKE_WAIT;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q != WAKE_RUN) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= WAKE_WAIT;
      cnt_q        <= '0;
      evt_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      evt_sticky_q <= evt_sticky_d;
    end
  end

  // Core reset asserts asynchronously with reset_l but always releases through the chain.
  logic rst_chain_in;
  assign rst_chain_in = (state_q == WAKE_RELEASE) || (state_q == WAKE_RUN);

  sync_chain #(.Stages(SyncStages)) u_rst_sync (
    .clk_i  (clk_i),
    .reset_l(reset_l),
    .d_i    (rst_chain_in),
    .q_o    (core_rst_no)
  );

  logic [NrIrq-1:0] irq_sync;
  logic             ipi_sync, time_irq_sync, debug_req_sync;

  for (genvar i = 0; i < NrIrq; i++) begin : g_irq_sync
    sync_chain #(.Stages(SyncStages)) u_irq_sync (
      .clk_i  (clk_i),
      .reset_l(reset_l),
      .d_i    (irq_async_i[i]),
      .q_o    (irq_sync[i])
    );
  end

  sync_chain #(.Stages(SyncStages)) u_ipi_sync (
    .clk_i  (clk_i),
    .reset_l(reset_l),
    .d_i    (ipi_async_i),
    .q_o    (ipi_sync)
  );

  sync_chain #(.Stages(SyncStages)) u_time_irq_sync (
    .clk_i  (clk_i),
    .reset_l(reset_l),
    .d_i    (time_irq_async_i),
    .q_o    (time_irq_sync)
  );

  sync_chain #(.Stages(SyncStages)) u_debug_req_sync (
    .clk_i  (clk_i),
    .reset_l(reset_l),
    .d_i    (debug_req_async_i),
    .q_o    (debug_req_sync)
  );

  // Gating by core_rst_no keeps interrupts captured during reset from reaching the core.
  assign irq_o       = irq_sync & {NrIrq{core_rst_no}};
  assign ipi_o       = ipi_sync & core_rst_no;
  assign time_irq_o  = time_irq_sync & core_rst_no;
  assign debug_req_o = debug_req_sync & core_rst_no;

  assign state_o     = state_q;
  assign wake_done_o = (state_q == WAKE_RUN);

endmodule

// File: tb/tb_ariane_wakeup_ctrl.sv
// Bench for ariane_wakeup_ctrl: one instance per wake mode, directed scenarios plus a
// randomized run against a phase/delay-line reference model.
module tb_ariane_wakeup_ctrl;

  localparam int unsigned WakeCycles = 16;
  localparam int unsigned SyncStages = 2;
  localparam int unsigned NrIrq      = 2;
  localparam int unsigned HoldCycles = 8;
  localparam int          NrInst     = 3;
  localparam int          NrBits     = NrIrq + 3;

  logic             clk_i             = 1'b0;
  logic             reset_l           = 1'b0;
  logic             wake_evt_i        = 1'b0;
  logic             soft_rst_req_i    = 1'b0;
  logic [NrIrq-1:0] irq_async_i       = '0;
  logic             ipi_async_i       = 1'b0;
  logic             time_irq_async_i  = 1'b0;
  logic             debug_req_async_i = 1'b0;

  logic             core_rst_no [NrInst];
  logic [NrIrq-1:0] irq_o       [NrInst];
  logic             ipi_o       [NrInst];
  logic             time_irq_o  [NrInst];
  logic             debug_req_o [NrInst];
  logic [1:0]       state_o     [NrInst];
  logic             wake_done_o [NrInst];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  // Instance 0: COUNT, 1: EVENT, 2: COUNT_AND_EVENT.
  for (genvar g = 0; g < NrInst; g++) begin : g_dut
    ariane_wakeup_ctrl #(
      .WakeMode  (g),
      .WakeCycles(WakeCycles),
      .SyncStages(SyncStages),
      .NrIrq     (NrIrq),
      .HoldCycles(HoldCycles)
    ) u_dut (
      .clk_i            (clk_i),
      .reset_l          (reset_l),
      .wake_evt_i       (wake_evt_i),
      .soft_rst_req_i   (soft_rst_req_i),
      .irq_async_i      (irq_async_i),
      .ipi_async_i      (ipi_async_i),
      .time_irq_async_i (time_irq_async_i),
      .debug_req_async_i(debug_req_async_i),
      .core_rst_no      (core_rst_no[g]),
      .irq_o            (irq_o[g]),
      .ipi_o            (ipi_o[g]),
      .time_irq_o       (time_irq_o[g]),
      .debug_req_o      (debug_req_o[g]),
      .state_o          (state_o[g]),
      .wake_done_o      (wake_done_o[g])
    );
  end

  // Reference model: phase number, edges spent in the phase, sticky event,
  // plus delay lines for the reset chain and the interrupt inputs.
  int                mdl_st  [NrInst];
  int                mdl_age [NrInst];
  bit                mdl_evt [NrInst];
  bit [SyncStages-1:0] mdl_rst [NrInst];
  logic [NrBits-1:0] mdl_hist[$];

  function automatic logic [NrBits-1:0] in_bits();
    return {debug_req_async_i, time_irq_async_i, ipi_async_i, irq_async_i};
  endfunction

  task automatic set_in_bits(input logic [NrBits-1:0] v);
    {debug_req_async_i, time_irq_async_i, ipi_async_i, irq_async_i} = v;
  endtask

  function automatic logic [NrBits-1:0] dut_ints(input int m);
    return {debug_req_o[m], time_irq_o[m], ipi_o[m], irq_o[m]};
  endfunction

  function automatic logic exp_rst(input int m);
    return mdl_rst[m][SyncStages-1];
  endfunction

  function automatic logic [NrBits-1:0] exp_ints(input int m);
    if (mdl_hist.size() >= SyncStages && exp_rst(m)) return mdl_hist[SyncStages-1];
    return '0;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < NrInst; m++) begin
      mdl_st[m]  = 0;
      mdl_age[m] = 0;
      mdl_evt[m] = 1'b0;
      mdl_rst[m] = '0;
    end
    mdl_hist.delete();
  endfunction

  function automatic void model_edge();
    int nxt;
    bit cnt_met, evt_any, go;
    for (int m = 0; m < NrInst; m++) begin
      mdl_rst[m] = {mdl_rst[m][SyncStages-2:0], (mdl_st[m] == 1 || mdl_st[m] == 2)};
      nxt = mdl_st[m];
      case (mdl_st[m])
        0: begin
          cnt_met = (mdl_age[m] + 1 >= WakeCycles);
          evt_any = wake_evt_i || mdl_evt[m];
          go = (m == 0) ? cnt_met : (m == 1) ? wake_evt_i : (cnt_met && evt_any);
          if (go) nxt = 1;
          else mdl_evt[m] = evt_any;
        end
        1: if (mdl_age[m] + 1 == SyncStages) nxt = 2;
        2: if (soft_rst_req_i) nxt = 3;
        default: if (mdl_age[m] + 1 == HoldCycles) nxt = 1;
      endcase
      if (nxt != mdl_st[m]) begin
        mdl_st[m]  = nxt;
        mdl_age[m] = 0;
        mdl_evt[m] = 1'b0;
      end else begin
        mdl_age[m]++;
      end
    end
    mdl_hist.push_front(in_bits());
    if (mdl_hist.size() > SyncStages) void'(mdl_hist.pop_back());
  endfunction

  task automatic step();
    @(posedge clk_i);
    if (reset_l) model_edge();
    #1;
  endtask

  task automatic restart();
    reset_l = 1'b0;
    #2;
    model_reset();
    step();
    reset_l = 1'b1;
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    set_in_bits('1);
    #3;
    model_reset();
    for (int m = 0; m < NrInst; m++) begin
      n_checks++;
      if (state_o[m] !== 2'd0) begin
        n_fail++; $display("[TB] FAIL reset_state[%0d]: got %0d want 0", m, state_o[m]);
      end
      n_checks++;
      if (core_rst_no[m] !== 1'b0) begin
        n_fail++; $display("[TB] FAIL reset_core_rst[%0d]: got %b want 0", m, core_rst_no[m]);
      end
      n_checks++;
      if (wake_done_o[m] !== 1'b0 || dut_ints(m) !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_outs[%0d]: got done=%b ints=%b want 0", m, wake_done_o[m],
                 dut_ints(m));
      end
    end
    step();
    step();
    reset_l = 1'b1;
  endtask

  task automatic test_count_wake();
    for (int k = 0; k < 18; k++) begin
      wake_evt_i = (k == 3);
      step();
      if (k < 15) begin
        n_checks++;
        if (state_o[0] !== 2'd0 || core_rst_no[0] !== 1'b0 || dut_ints(0) !== '0) begin
          n_fail++;
          $display("[TB] FAIL wait_gated k=%0d: got st=%0d rst=%b ints=%b want 0/0/0", k,
                   state_o[0], core_rst_no[0], dut_ints(0));
        end
      end
      if (k == 3) begin
        n_checks++;
        if (state_o[1] !== 2'd1) begin
          n_fail++; $display("[TB] FAIL event_release_early: got %0d want 1", state_o[1]);
        end
      end
      if (k == 15) begin
        n_checks++;
        if (state_o[0] !== 2'd1 || state_o[2] !== 2'd1) begin
          n_fail++;
          $display("[TB] FAIL count_release: got count=%0d cae=%0d want 1/1", state_o[0],
                   state_o[2]);
        end
      end
      if (k == 17) begin
        n_checks++;
        if (state_o[0] !== 2'd2 || core_rst_no[0] !== 1'b1 || wake_done_o[0] !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL count_run: got st=%0d rst=%b done=%b want 2/1/1", state_o[0],
                   core_rst_no[0], wake_done_o[0]);
        end
        n_checks++;
        if (dut_ints(0) !== '1) begin
          n_fail++; $display("[TB] FAIL run_ints: got %b want all ones", dut_ints(0));
        end
      end
    end
    wake_evt_i = 1'b0;
  endtask

  task automatic test_irq_sync();
    logic [NrBits-1:0] cur, nxt;
    for (int b = 0; b < NrBits; b++) begin
      cur = in_bits();
      nxt = cur ^ (NrBits'(1) << b);
      set_in_bits(nxt);
      step();
      n_checks++;
      if (dut_ints(0) !== cur) begin
        n_fail++; $display("[TB] FAIL sync_lat1 bit%0d: got %b want %b", b, dut_ints(0), cur);
      end
      step();
      n_checks++;
      if (dut_ints(0) !== nxt) begin
        n_fail++; $display("[TB] FAIL sync_lat2 bit%0d: got %b want %b", b, dut_ints(0), nxt);
      end
      set_in_bits(cur);
      step();
      step();
      n_checks++;
      if (dut_ints(0) !== cur) begin
        n_fail++; $display("[TB] FAIL sync_back bit%0d: got %b want %b", b, dut_ints(0), cur);
      end
    end
  endtask

  task automatic test_soft_reset();
    int exp_st;
    for (int i = 0; i <= 10; i++) begin
      soft_rst_req_i = (i == 0 || i == 3);
      step();
      exp_st = (i < HoldCycles) ? 3 : (i < HoldCycles + SyncStages) ? 1 : 2;
      for (int m = 0; m < NrInst; m++) begin
        n_checks++;
        if (state_o[m] !== 2'(exp_st)) begin
          n_fail++;
          $display("[TB] FAIL hold_seq[%0d] i=%0d: got %0d want %0d", m, i, state_o[m], exp_st);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (core_rst_no[0] !== 1'b1) begin
          n_fail++; $display("[TB] FAIL hold_rst_early: got %b want 1", core_rst_no[0]);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (core_rst_no[0] !== 1'b0 || dut_ints(0) !== '0) begin
          n_fail++;
          $display("[TB] FAIL hold_rst_low: got rst=%b ints=%b want 0/0", core_rst_no[0],
                   dut_ints(0));
        end
      end
      if (i == 10) begin
        n_checks++;
        if (core_rst_no[0] !== 1'b1 || dut_ints(0) !== '1) begin
          n_fail++;
          $display("[TB] FAIL rerun: got rst=%b ints=%b want 1/all ones", core_rst_no[0],
                   dut_ints(0));
        end
      end
    end
    soft_rst_req_i = 1'b0;
  endtask

  task automatic test_event_timing();
    restart();
    for (int k = 0; k <= 102; k++) begin
      wake_evt_i = (k == 100);
      step();
      if (k == 99) begin
        n_checks++;
        if (state_o[1] !== 2'd0 || core_rst_no[1] !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL evt_pre: got st=%0d rst=%b want 0/0", state_o[1], core_rst_no[1]);
        end
      end
      if (k == 100) begin
        n_checks++;
        if (state_o[1] !== 2'd1) begin
          n_fail++; $display("[TB] FAIL evt_release: got %0d want 1", state_o[1]);
        end
      end
      if (k == 102) begin
        n_checks++;
        if (core_rst_no[1] !== 1'b1 || state_o[1] !== 2'd2) begin
          n_fail++;
          $display("[TB] FAIL evt_run: got st=%0d rst=%b want 2/1", state_o[1], core_rst_no[1]);
        end
      end
    end
    restart();
    for (int k = 0; k <= 40; k++) begin
      wake_evt_i = (k == 40);
      step();
      if (k == 39) begin
        n_checks++;
        if (state_o[2] !== 2'd0) begin
          n_fail++; $display("[TB] FAIL cae_late_pre: got %0d want 0", state_o[2]);
        end
      end
      if (k == 40) begin
        n_checks++;
        if (state_o[2] !== 2'd1) begin
          n_fail++; $display("[TB] FAIL cae_late_release: got %0d want 1", state_o[2]);
        end
      end
    end
    wake_evt_i = 1'b0;
    restart();
    repeat (10000) step();
    n_checks++;
    if (state_o[1] !== 2'd0 || core_rst_no[1] !== 1'b0 || wake_done_o[1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL evt_never: got st=%0d rst=%b done=%b want 0/0/0", state_o[1],
               core_rst_no[1], wake_done_o[1]);
    end
  endtask

  task automatic test_async_abort();
    set_in_bits('1);
    restart();
    for (int k = 0; k <= 16; k++) begin
      wake_evt_i = (k == 3);
      step();
    end
    wake_evt_i = 1'b0;
    #2 reset_l = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < NrInst; m++) begin
      n_checks++;
      if (state_o[m] !== 2'd0 || core_rst_no[m] !== 1'b0 || wake_done_o[m] !== 1'b0 ||
          dut_ints(m) !== '0) begin
        n_fail++;
        $display("[TB] FAIL abort_release[%0d]: got st=%0d rst=%b done=%b ints=%b want 0", m,
                 state_o[m], core_rst_no[m], wake_done_o[m], dut_ints(m));
      end
    end
    step();
    reset_l = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      wake_evt_i = (k == 3);
      step();
    end
    wake_evt_i = 1'b0;
    #2 reset_l = 1'b0;
    #1;
    model_reset();
    step();
    reset_l = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      step();
      if (k == 15) begin
        n_checks++;
        if (state_o[0] !== 2'd1 || state_o[2] !== 2'd0) begin
          n_fail++;
          $display("[TB] FAIL sticky_cleared: got count=%0d cae=%0d want 1/0", state_o[0],
                   state_o[2]);
        end
      end
    end
    soft_rst_req_i = 1'b1;
    step();
    soft_rst_req_i = 1'b0;
    step();
    #2 reset_l = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (state_o[0] !== 2'd0 || core_rst_no[0] !== 1'b0 || dut_ints(0) !== '0) begin
      n_fail++;
      $display("[TB] FAIL abort_hold: got st=%0d rst=%b ints=%b want 0/0/0", state_o[0],
               core_rst_no[0], dut_ints(0));
    end
    step();
    reset_l = 1'b1;
    for (int k = 0; k <= 15; k++) step();
    n_checks++;
    if (state_o[0] !== 2'd1) begin
      n_fail++; $display("[TB] FAIL abort_restart: got %0d want 1", state_o[0]);
    end
  endtask

  task automatic test_random();
    restart();
    for (int c = 0; c < 3000; c++) begin
      wake_evt_i     = ($urandom_range(0, 39) == 0);
      soft_rst_req_i = ($urandom_range(0, 19) == 0);
      set_in_bits(in_bits() ^ NrBits'($urandom & $urandom));
      if ($urandom_range(0, 599) == 0) begin
        #2 reset_l = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < NrInst; m++) begin
          n_checks++;
          if (state_o[m] !== 2'd0 || core_rst_no[m] !== 1'b0 || dut_ints(m) !== '0) begin
            n_fail++;
            $display("[TB] FAIL rnd_abort[%0d] c=%0d: got st=%0d rst=%b ints=%b want 0", m, c,
                     state_o[m], core_rst_no[m], dut_ints(m));
          end
        end
        step();
        reset_l = 1'b1;
      end else begin
        step();
        for (int m = 0; m < NrInst; m++) begin
          n_checks++;
          if (state_o[m] !== 2'(mdl_st[m])) begin
            n_fail++;
            $display("[TB] FAIL rnd_state[%0d] c=%0d: got %0d want %0d", m, c, state_o[m],
                     mdl_st[m]);
          end
          n_checks++;
          if (core_rst_no[m] !== exp_rst(m)) begin
            n_fail++;
            $display("[TB] FAIL rnd_core_rst[%0d] c=%0d: got %b want %b", m, c, core_rst_no[m],
                     exp_rst(m));
          end
          n_checks++;
          if (wake_done_o[m] !== (mdl_st[m] == 2)) begin
            n_fail++;
            $display("[TB] FAIL rnd_done[%0d] c=%0d: got %b want %b", m, c, wake_done_o[m],
                     (mdl_st[m] == 2));
          end
          n_checks++;
          if (dut_ints(m) !== exp_ints(m)) begin
            n_fail++;
            $display("[TB] FAIL rnd_ints[%0d] c=%0d: got %b want %b", m, c, dut_ints(m),
                     exp_ints(m));
          end
        end
      end
    end
    wake_evt_i     = 1'b0;
    soft_rst_req_i = 1'b0;
  endtask

  initial begin
    $display("[TB] starting ariane_wakeup_ctrl bench");
    test_reset();
    test_count_wake();
    test_irq_sync();
    test_soft_reset();
    test_event_timing();
    test_async_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
